// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared geometry, colors and scan states for the 5x5 LED matrix
package led_matrix_pkg;

  localparam int ROWS      = 5;
  localparam int COLS      = 5;
  localparam int PIX_W     = 2;
  localparam int FRAME_W   = 50;
  localparam int ROW_PIX_W = COLS * PIX_W;

  localparam logic [PIX_W-1:0] OFF = 2'b00;
  localparam logic [PIX_W-1:0] C1  = 2'b01;
  localparam logic [PIX_W-1:0] C2  = 2'b10;
  localparam logic [PIX_W-1:0] C3  = 2'b11;

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} scan_state_t;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  function automatic logic [2:0] next_row(input logic [2:0] r);
    return (r == LAST_ROW) ? 3'd0 : r + 3'd1;
  endfunction

endpackage

// File: rtl/led_row_drive.sv
// rtl/led_row_drive.sv - one-cold row select and row-masked pixel bus for a frame
module led_row_drive
  import led_matrix_pkg::*;
(
  input  logic [2:0]         row,
  input  logic [FRAME_W-1:0] frame,
  input  logic               on,
  output logic [ROWS-1:0]    gnd,
  output logic [FRAME_W-1:0] outbus
);

  always_comb begin
    gnd    = '1;
    outbus = {(ROWS * COLS){OFF}};
    for (int r = 0; r < ROWS; r++) begin
      if (on && (row == 3'(r))) begin
        gnd[r] = 1'b0;
        outbus[r*ROW_PIX_W +: ROW_PIX_W] = frame[r*ROW_PIX_W +: ROW_PIX_W];
      end
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - row-scan controller with shadow frame buffer and tear-free swap
// SCAN_BLANK_EN adds BLANK_CYC all-off cycles after every row.
module led_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [FRAME_W-1:0] Outbus,
  output logic [ROWS-1:0]    Gnd,
  output logic               frame_start,
  output logic               swap_done
);

  scan_state_t        state, state_n;
  logic [2:0]         row, row_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n, dwell_m1;
  logic [FRAME_W-1:0] active, shadow, drive_frame, drive_out;
  logic [ROWS-1:0]    drive_gnd;
  logic               pending, accept, swap, row_start;

`ifdef SCAN_BLANK_EN
  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  logic [BLANK_W-1:0] blank_cnt, blank_cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_cnt <= '0;
    else        blank_cnt <= blank_cnt_n;
  end
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = (BLANK_CYC != 0);
`endif

  assign frame_ready = ~pending;
  assign accept      = frame_valid & ~pending;
  // Dwell counts down from dwell_eff-1, so a programmed 0 still yields one cycle.
  assign dwell_m1    = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  always_comb begin
    state_n     = state;
    row_n       = row;
    dwell_cnt_n = dwell_cnt;
    row_start   = 1'b0;
    swap        = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_cnt_n = blank_cnt;
`endif
    case (state)
      IDLE: begin
        if (enable) begin
          state_n   = SCAN;
          row_n     = '0;
          row_start = 1'b1;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_n = IDLE;
          row_n   = '0;
        end else if (dwell_cnt == '0) begin
          swap = pending && (row == LAST_ROW);
`ifdef SCAN_BLANK_EN
          state_n     = BLANK;
          blank_cnt_n = BLANK_W'(BLANK_CYC - 1);
`else
          row_n     = next_row(row);
          row_start = 1'b1;
`endif
        end else begin
          dwell_cnt_n = dwell_cnt - DWELL_W'(1);
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (!enable) begin
          state_n = IDLE;
          row_n   = '0;
        end else if (blank_cnt == '0) begin
          state_n   = SCAN;
          row_n     = next_row(row);
          row_start = 1'b1;
        end else begin
          blank_cnt_n = blank_cnt - BLANK_W'(1);
        end
      end
`endif
      default: begin
        state_n = IDLE;
        row_n   = '0;
      end
    endcase
    if (row_start) dwell_cnt_n = dwell_m1;
  end

  // Outputs are computed from next-state values so the pins line up with the state register.
  assign drive_frame = swap ? shadow : active;

  led_row_drive u_row_drive (
    .row    (row_n),
    .frame  (drive_frame),
    .on     (state_n == SCAN),
    .gnd    (drive_gnd),
    .outbus (drive_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row         <= '0;
      dwell_cnt   <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      Outbus      <= '0;
      Gnd         <= '1;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      state       <= state_n;
      row         <= row_n;
      dwell_cnt   <= dwell_cnt_n;
      Outbus      <= drive_out;
      Gnd         <= drive_gnd;
      frame_start <= row_start && (row_n == '0);
      swap_done   <= swap;
      if (accept) begin
        shadow  <= frame_in;
        pending <= 1'b1;
      end else if (swap) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - randomized self-checking bench for led_scan_ctrl against a timing-formula model
module tb_led_scan_ctrl;
  import led_matrix_pkg::*;

`ifdef SCAN_BLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif

  logic              clk, rst_n, enable, frame_valid;
  logic [15:0]       dwell;
  logic [FRAME_W-1:0] frame_in, Outbus;
  logic              frame_ready, frame_start, swap_done;
  logic [ROWS-1:0]   Gnd;

  led_scan_ctrl #(.DWELL_W(16), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dwell(dwell),
    .frame_in(frame_in), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .Outbus(Outbus), .Gnd(Gnd), .frame_start(frame_start), .swap_done(swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: position in the scan is a cycle count since row 0 started.
  bit                 m_scan, m_pend;
  int                 m_t, m_de, m_per;
  logic [FRAME_W-1:0] m_active, m_shadow;
  logic [ROWS-1:0]    e_gnd;
  logic [FRAME_W-1:0] e_out;
  bit                 e_fs, e_sd;

  task automatic model_reset();
    m_scan = 0; m_pend = 0; m_t = 0; m_de = 1; m_per = 1 + BLK;
    m_active = '0; m_shadow = '0;
    e_gnd = '1; e_out = '0; e_fs = 0; e_sd = 0;
  endtask

  task automatic model_edge();
    bit swp;
    int r;
    swp = 0;
    if (m_scan && enable) begin
      if ((m_t / m_per == 4) && (m_t % m_per == m_de - 1) && m_pend) swp = 1;
      m_t++;
      if (m_t == 5 * m_per) m_t = 0;
    end else if (m_scan) begin
      m_scan = 0;
    end else if (enable) begin
      m_scan = 1; m_t = 0;
      m_de = (dwell == 0) ? 1 : int'(dwell);
      m_per = m_de + BLK;
    end
    e_sd = swp;
    if (frame_valid && !m_pend) begin
      m_shadow = frame_in; m_pend = 1;
    end else if (swp) begin
      m_active = m_shadow; m_pend = 0;
    end
    e_gnd = '1; e_out = '0;
    if (m_scan && (m_t % m_per < m_de)) begin
      r = m_t / m_per;
      e_gnd[r] = 1'b0;
      e_out[10*r +: 10] = m_active[10*r +: 10];
    end
    e_fs = m_scan && (m_t == 0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; frame_valid = 1'b0; dwell = 16'd3; frame_in = '0;
    model_reset();
    #12;
    checks++;
    if (Gnd !== 5'b11111 || Outbus !== '0 || frame_ready !== 1'b1 || frame_start !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init gnd=%b out=%h rdy=%b fs=%b sd=%b", Gnd, Outbus, frame_ready, frame_start, swap_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    enable = 1'b1; frame_valid = 1'b1; frame_in = {25{C2}};
    tick();
    frame_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (Gnd === 5'b11111) begin
      errors++;
      $display("FAIL reset_prescan gnd=%b required a selected row", Gnd);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Gnd !== 5'b11111 || Outbus !== '0 || frame_ready !== 1'b1 || frame_start !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async gnd=%b out=%h rdy=%b fs=%b sd=%b", Gnd, Outbus, frame_ready, frame_start, swap_done);
    end
    enable = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_scan_dwell3();
    logic [ROWS-1:0]    g;
    logic [FRAME_W-1:0] o;
    int r;
    dwell = 16'd3; frame_in = {25{C1}}; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0; enable = 1'b1;
    for (int k = 0; k < 45; k++) begin
      tick();
      r = (k / (3 + BLK)) % 5;
      g = 5'b11111; o = '0;
      if (k % (3 + BLK) < 3) begin
        g[r] = 1'b0;
        if (k >= 5 * (3 + BLK)) o[10*r +: 10] = 10'h155;
      end
      checks++;
      if (Gnd !== g || Outbus !== o || frame_start !== (k % (5 * (3 + BLK)) == 0)) begin
        errors++;
        $display("FAIL dwell3_table k=%0d gnd=%b/%b out=%h/%h fs=%b", k, Gnd, g, Outbus, o, frame_start);
      end
      checks++;
      if (Gnd !== e_gnd || Outbus !== e_out || frame_start !== e_fs || swap_done !== e_sd || frame_ready !== !m_pend) begin
        errors++;
        $display("FAIL dwell3_model k=%0d gnd=%b/%b out=%h/%h fs=%b/%b sd=%b/%b rdy=%b/%b",
                 k, Gnd, e_gnd, Outbus, e_out, frame_start, e_fs, swap_done, e_sd, frame_ready, !m_pend);
      end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_boundary_swap();
    int  n;
    bit  seen;
    dwell = 16'd2; enable = 1'b1;
    n = 0;
    while (!(m_scan && (m_t / m_per == 1)) && n < 50) begin tick(); n++; end
    frame_in = {25{C3}}; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      checks++;
      if (Gnd !== e_gnd || Outbus !== e_out || frame_start !== e_fs || swap_done !== e_sd || frame_ready !== !m_pend) begin
        errors++;
        $display("FAIL swap_model k=%0d gnd=%b/%b out=%h/%h fs=%b/%b sd=%b/%b rdy=%b/%b",
                 k, Gnd, e_gnd, Outbus, e_out, frame_start, e_fs, swap_done, e_sd, frame_ready, !m_pend);
      end
      if (swap_done === 1'b1) begin
        seen = 1;
        checks++;
        if (frame_ready !== 1'b1) begin
          errors++;
          $display("FAIL swap_ready rdy=%b required 1", frame_ready);
        end
      end else begin
        checks++;
        if (frame_ready !== 1'b0) begin
          errors++;
          $display("FAIL swap_hold k=%0d rdy=%b required 0", k, frame_ready);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL swap_timeout swap_done=0 required a pulse");
    end
    repeat (BLK) tick();
    checks++;
    if (Gnd !== 5'b11110 || Outbus[9:0] !== 10'h3FF || Outbus[49:10] !== '0) begin
      errors++;
      $display("FAIL swap_row0 gnd=%b out=%h required 11110 with row0=3ff", Gnd, Outbus);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_dwell0();
    logic [ROWS-1:0] g;
    dwell = 16'd0; enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      g = 5'b11111;
      if (k % (1 + BLK) == 0) g[(k / (1 + BLK)) % 5] = 1'b0;
      checks++;
      if (Gnd !== g || Outbus !== e_out) begin
        errors++;
        $display("FAIL dwell0 k=%0d gnd=%b/%b out=%h/%h", k, Gnd, g, Outbus, e_out);
      end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop();
    int n;
    dwell = 16'd2; enable = 1'b1;
    n = 0;
    while (!(m_scan && (m_t / m_per == 2)) && n < 50) begin tick(); n++; end
    checks++;
    if (Gnd !== 5'b11011) begin
      errors++;
      $display("FAIL drop_row2 gnd=%b required 11011", Gnd);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (Gnd !== 5'b11111 || Outbus !== '0) begin
      errors++;
      $display("FAIL drop_idle gnd=%b out=%h required 11111 and 0", Gnd, Outbus);
    end
    repeat (2) tick();
    enable = 1'b1;
    tick();
    checks++;
    if (Gnd !== 5'b11110 || frame_start !== 1'b1 || Outbus[9:0] !== m_active[9:0]) begin
      errors++;
      $display("FAIL drop_resume gnd=%b fs=%b out=%h row0=%h required 11110 fs=1", Gnd, frame_start, Outbus, m_active[9:0]);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      frame_valid = ($urandom_range(0, 3) == 0);
      frame_in = FRAME_W'({$urandom(), $urandom()});
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if (!enable) dwell = 16'($urandom_range(0, 4));
      tick();
      checks++;
      if (Gnd !== e_gnd || Outbus !== e_out || frame_start !== e_fs || swap_done !== e_sd || frame_ready !== !m_pend) begin
        errors++;
        $display("FAIL random k=%0d gnd=%b/%b out=%h/%h fs=%b/%b sd=%b/%b rdy=%b/%b",
                 k, Gnd, e_gnd, Outbus, e_out, frame_start, e_fs, swap_done, e_sd, frame_ready, !m_pend);
      end
    end
    enable = 1'b0; frame_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_scan_dwell3();
    test_boundary_swap();
    test_dwell0();
    test_enable_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
